// File: rtl/cgra_sram_arb_pkg.sv
// Shared types for the CGRA SRAM arbiter: power-sequencing FSM states and
// the response-tracking record that pairs a granted access with its port.
// No ports; imported by cgra_sram_arbiter and cgra_rr_arbiter.
package cgra_sram_arb_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned BeWidth   = DataWidth / 8;
    localparam int unsigned MaxPorts  = 8;
    localparam int unsigned PortIdxW  = $clog2(MaxPorts);

    typedef enum logic [1:0] {
        ST_ACTIVE    = 2'd0,
        ST_RETENTIVE = 2'd1,
        ST_WAKE      = 2'd2
    } arb_state_e;

    // One access in flight: response is due on the cycle after the grant.
    typedef struct packed {
        logic                valid;
        logic [PortIdxW-1:0] port;
    } resp_t;

endpackage

// File: rtl/cgra_rr_arbiter.sv
// Combinational round-robin pick. The port at ptr_i has highest priority,
// then ptr_i+1, ... wrapping at NumPorts. The pointer register is owned by
// the caller.
//   req_i   : per-port request vector
//   ptr_i   : index of the highest-priority port
//   gnt_o   : one-hot grant (all zero when no request)
//   idx_o   : index of the granted port
//   valid_o : a port was picked
module cgra_rr_arbiter
    import cgra_sram_arb_pkg::*;
#(
    parameter int unsigned NumPorts = 4,
    parameter int unsigned IdxW     = $clog2(NumPorts)
) (
    input  logic [NumPorts-1:0] req_i,
    input  logic [IdxW-1:0]     ptr_i,
    output logic [NumPorts-1:0] gnt_o,
    output logic [IdxW-1:0]     idx_o,
    output logic                valid_o
);

    logic [IdxW-1:0] cand;
    logic            found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = IdxW'((32'(ptr_i) + i) % NumPorts);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/cgra_sram_arbiter.sv
// Round-robin arbiter and power sequencer for one single-port CGRA SRAM bank
// shared by NumPorts requesters. One access granted per cycle, response one
// cycle later. After IdleCycles idle cycles (with ret_en_i) the bank is put
// into retention; the next request wakes it after WakeCycles cycles.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   ret_en_i              : allow automatic retention
//   req_i/we_i/addr_i/wdata_i/be_i : per-port request and payload (flattened)
//   gnt_o                 : one-hot grant, combinational
//   rvalid_o              : one-hot response, one cycle after grant
//   rdata_o               : bank read data, broadcast
//   mem_*                 : bank access signals; mem_set_retentive_no=0 retains
module cgra_sram_arbiter
    import cgra_sram_arb_pkg::*;
#(
    parameter int unsigned NumPorts   = 4,
    parameter int unsigned NumWords   = 1024,
    parameter int unsigned AddrWidth  = $clog2(NumWords),
    parameter int unsigned IdleCycles = 64,
    parameter int unsigned WakeCycles = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ret_en_i,
    input  logic [NumPorts-1:0]           req_i,
    input  logic [NumPorts-1:0]           we_i,
    input  logic [NumPorts*AddrWidth-1:0] addr_i,
    input  logic [NumPorts*DataWidth-1:0] wdata_i,
    input  logic [NumPorts*BeWidth-1:0]   be_i,
    output logic [NumPorts-1:0]           gnt_o,
    output logic [NumPorts-1:0]           rvalid_o,
    output logic [DataWidth-1:0]          rdata_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [DataWidth-1:0]          mem_wdata_o,
    output logic [BeWidth-1:0]            mem_be_o,
    input  logic [DataWidth-1:0]          mem_rdata_i,
    output logic                          mem_set_retentive_no
);

    localparam int unsigned IdxW  = $clog2(NumPorts);
    localparam int unsigned IdleW = $clog2(IdleCycles + 1);
    localparam int unsigned WakeW = $clog2(WakeCycles + 1);
    localparam logic [IdleW-1:0] IdleMax  = IdleW'(IdleCycles);
    localparam logic [WakeW-1:0] WakeLast = WakeW'(WakeCycles - 1);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumPorts - 1);

    arb_state_e        state_q, state_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [WakeW-1:0]  wake_q, wake_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    resp_t             resp_q, resp_d;

    logic [NumPorts-1:0] arb_gnt;
    logic [IdxW-1:0]     arb_idx;
    logic                arb_valid;
    logic                grant;

    cgra_rr_arbiter #(
        .NumPorts (NumPorts)
    ) u_rr (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Grants and responses are suppressed while reset is held so that no
    // access starts and a pending response is dropped in the reset cycle.
    assign grant                = (state_q == ST_ACTIVE) && arb_valid && !rst_i;
    assign gnt_o                = grant ? arb_gnt : '0;
    assign mem_req_o            = grant;
    assign mem_set_retentive_no = (state_q != ST_RETENTIVE);
    assign rdata_o              = mem_rdata_i;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (gnt_o[i]) begin
                mem_we_o    = we_i[i];
                mem_addr_o  = addr_i[i*AddrWidth +: AddrWidth];
                mem_wdata_o = wdata_i[i*DataWidth +: DataWidth];
                mem_be_o    = be_i[i*BeWidth +: BeWidth];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            rvalid_o[i] = resp_q.valid && !rst_i && (resp_q.port == PortIdxW'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        ptr_d   = ptr_q;
        resp_d  = '0;
        unique case (state_q)
            ST_ACTIVE: begin
                if (arb_valid) begin
                    idle_d      = '0;
                    ptr_d       = (arb_idx == LastIdx) ? '0 : arb_idx + IdxW'(1);
                    resp_d.valid = 1'b1;
                    resp_d.port  = PortIdxW'(arb_idx);
                end else if (idle_q == IdleMax) begin
                    // Saturated: retire only once the last response is out.
                    if (ret_en_i && !resp_q.valid) begin
                        state_d = ST_RETENTIVE;
                        idle_d  = '0;
                    end
                end else begin
                    idle_d = idle_q + IdleW'(1);
                end
            end
            ST_RETENTIVE: begin
                if ((|req_i) || !ret_en_i) begin
                    state_d = ST_WAKE;
                    wake_d  = '0;
                end
            end
            ST_WAKE: begin
                if (wake_q == WakeLast) begin
                    state_d = ST_ACTIVE;
                    wake_d  = '0;
                    idle_d  = '0;
                end else begin
                    wake_d = wake_q + WakeW'(1);
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ACTIVE;
            idle_q  <= '0;
            wake_q  <= '0;
            ptr_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
            ptr_q   <= ptr_d;
            resp_q  <= resp_d;
        end
    end

endmodule

// File: tb/tb_cgra_sram_arbiter.sv
// Bench for cgra_sram_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the arbiter and a
// reference copy of the bank contents.
module tb_cgra_sram_arbiter;

    localparam int NP    = 4;
    localparam int AW    = 10;
    localparam int IDLE  = 64;
    localparam int WAKE  = 4;
    localparam int NADDR = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ret_en = 1'b0;
    logic [NP-1:0]    req = '0;
    logic [NP-1:0]    we = '0;
    logic [NP*AW-1:0] addr = '0;
    logic [NP*32-1:0] wdata = '0;
    logic [NP*4-1:0]  be = '0;

    logic [NP-1:0] gnt_o, rvalid_o;
    logic [31:0]   rdata_o;
    logic          mem_req_o, mem_we_o, mem_set_retentive_no;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic [31:0]   bank_rdata = '0;

    always #5 clk = ~clk;

    cgra_sram_arbiter #(
        .NumPorts   (NP),
        .NumWords   (1024),
        .IdleCycles (IDLE),
        .WakeCycles (WAKE)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .ret_en_i             (ret_en),
        .req_i                (req),
        .we_i                 (we),
        .addr_i               (addr),
        .wdata_i              (wdata),
        .be_i                 (be),
        .gnt_o                (gnt_o),
        .rvalid_o             (rvalid_o),
        .rdata_o              (rdata_o),
        .mem_req_o            (mem_req_o),
        .mem_we_o             (mem_we_o),
        .mem_addr_o           (mem_addr_o),
        .mem_wdata_o          (mem_wdata_o),
        .mem_be_o             (mem_be_o),
        .mem_rdata_i          (bank_rdata),
        .mem_set_retentive_no (mem_set_retentive_no)
    );

    // Single-port bank with one-cycle read latency.
    logic [31:0] bank [1024];
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) bank[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                bank_rdata <= bank[mem_addr_o];
            end
        end
    end

    int vectors = 0;
    int errors  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural model: mode 0 = serving, 1 = retained, 2 = waking.
    int          m_mode = 0;
    int          m_idle = 0;
    int          m_wake_left = 0;
    int          m_last = NP - 1;
    int          m_pend = -1;
    bit          m_pend_rd = 0;
    logic [31:0] m_pend_data = '0;
    logic [31:0] ref_mem [1024];
    logic [NP-1:0] gnt_seen = '0;

    task automatic model_step();
        logic [NP-1:0] eg, ev;
        int p, c, a;
        bit had_pend;
        eg = '0;
        ev = '0;
        if (rst) begin
            check_eq("rst_gnt", 32'(gnt_o), 32'd0);
            check_eq("rst_rvalid", 32'(rvalid_o), 32'd0);
            check_eq("rst_memreq", 32'(mem_req_o), 32'd0);
            m_mode = 0; m_idle = 0; m_wake_left = 0; m_last = NP - 1;
            m_pend = -1; m_pend_rd = 0; gnt_seen = '0;
            return;
        end
        if (m_pend >= 0) ev[m_pend] = 1'b1;
        check_eq("rvalid", 32'(rvalid_o), 32'(ev));
        if (m_pend >= 0 && m_pend_rd) check_eq("rdata", rdata_o, m_pend_data);
        check_eq("retn", 32'(mem_set_retentive_no), 32'(m_mode != 1));
        p = -1;
        if (m_mode == 0) begin
            for (int k = 1; k <= NP; k++) begin
                c = (m_last + k) % NP;
                if (p < 0 && req[c]) p = c;
            end
        end
        if (p >= 0) eg[p] = 1'b1;
        check_eq("gnt", 32'(gnt_o), 32'(eg));
        check_eq("mem_req", 32'(mem_req_o), 32'(p >= 0));
        gnt_seen = gnt_o;
        had_pend = (m_pend >= 0);
        m_pend_rd = 0;
        m_pend = -1;
        if (p >= 0) begin
            a = int'(addr[p*AW +: AW]);
            check_eq("mem_addr", 32'(mem_addr_o), 32'(a));
            check_eq("mem_we", 32'(mem_we_o), 32'(we[p]));
            check_eq("mem_be", 32'(mem_be_o), 32'(be[p*4 +: 4]));
            if (we[p]) begin
                check_eq("mem_wdata", mem_wdata_o, wdata[p*32 +: 32]);
                for (int b = 0; b < 4; b++)
                    if (be[p*4 + b]) ref_mem[a][8*b +: 8] = wdata[p*32 + 8*b +: 8];
            end else begin
                m_pend_rd = 1;
                m_pend_data = ref_mem[a];
            end
            m_pend = p;
            m_last = p;
            m_idle = 0;
        end else if (m_mode == 0) begin
            if (m_idle >= IDLE && ret_en && !had_pend) begin
                m_mode = 1;
                m_idle = 0;
            end else if (m_idle < IDLE) begin
                m_idle++;
            end
        end else if (m_mode == 1) begin
            if (req != 0 || !ret_en) begin
                m_mode = 2;
                m_wake_left = WAKE;
            end
        end else begin
            m_wake_left--;
            if (m_wake_left == 0) begin
                m_mode = 0;
                m_idle = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    endtask

    task automatic set_port(input int p, input bit w, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] b);
        req[p] = 1'b1;
        we[p] = w;
        addr[p*AW +: AW] = a;
        wdata[p*32 +: 32] = d;
        be[p*4 +: 4] = b;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        clear_inputs();
        repeat (n) step();
        rst = 1'b0;
    endtask

    int cycles;
    int dens;
    logic [NP-1:0] exp_v;

    initial begin
        do_reset(3);
        check_eq("reset_gnt", 32'(gnt_o), 32'd0);
        check_eq("reset_rvalid", 32'(rvalid_o), 32'd0);
        check_eq("reset_memreq", 32'(mem_req_o), 32'd0);
        check_eq("reset_retn", 32'(mem_set_retentive_no), 32'd1);

        // Preload the address window used by all later traffic.
        for (int a = 0; a < NADDR; a++) begin
            clear_inputs();
            set_port(0, 1'b1, AW'(a), 32'hA500_0000 | 32'(a), 4'hF);
            step();
        end
        clear_inputs();
        step();

        // Single port write then read.
        set_port(0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
        #1 check_eq("t1_wr_gnt", 32'(gnt_o), 32'h1);
        step();
        clear_inputs();
        set_port(0, 1'b0, 10'h010, 32'h0, 4'hF);
        #1 check_eq("t1_rd_gnt", 32'(gnt_o), 32'h1);
        step();
        clear_inputs();
        #1;
        check_eq("t1_rvalid", 32'(rvalid_o), 32'h1);
        check_eq("t1_rdata", rdata_o, 32'hDEADBEEF);
        step();

        // All ports requesting continuously from reset.
        do_reset(2);
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, AW'(p + 1), 32'h0, 4'hF);
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_v = '0;
            exp_v[k % NP] = 1'b1;
            check_eq("rr_gnt", 32'(gnt_o), 32'(exp_v));
            if (k > 0) begin
                exp_v = '0;
                exp_v[(k - 1) % NP] = 1'b1;
                check_eq("rr_rvalid", 32'(rvalid_o), 32'(exp_v));
            end
            step();
        end
        clear_inputs();
        step();

        // Byte-enable merge.
        set_port(3, 1'b1, 10'h020, 32'hFFFFFFFF, 4'hF);
        step();
        set_port(3, 1'b1, 10'h020, 32'h11223344, 4'h3);
        step();
        set_port(3, 1'b0, 10'h020, 32'h0, 4'hF);
        step();
        clear_inputs();
        #1 check_eq("be_rdata", rdata_o, 32'hFFFF3344);
        step();

        // Retention entry and wake latency.
        ret_en = 1'b1;
        repeat (IDLE + 4) step();
        #1 check_eq("ret_entered", 32'(mem_set_retentive_no), 32'd0);
        set_port(2, 1'b0, 10'h010, 32'h0, 4'hF);
        cycles = 0;
        #1;
        while (!gnt_o[2] && cycles < 20) begin
            step();
            cycles++;
            #1;
        end
        check_eq("wake_latency", 32'(cycles), 32'd5);
        step();
        clear_inputs();
        #1;
        check_eq("wake_rvalid", 32'(rvalid_o), 32'h4);
        check_eq("wake_rdata", rdata_o, 32'hDEADBEEF);
        step();

        // Request on the threshold cycle wins over retention.
        do_reset(2);
        repeat (IDLE) step();
        set_port(1, 1'b0, 10'h010, 32'h0, 4'hF);
        #1 check_eq("thr_gnt", 32'(gnt_o), 32'h2);
        step();
        clear_inputs();
        repeat (3) begin
            #1 check_eq("thr_retn", 32'(mem_set_retentive_no), 32'd1);
            step();
        end
        ret_en = 1'b0;

        // Reset right after a read grant.
        set_port(1, 1'b0, 10'h010, 32'h0, 4'hF);
        step();
        clear_inputs();
        rst = 1'b1;
        #1 check_eq("rstmid_rvalid", 32'(rvalid_o), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check_eq("rstmid_gnt", 32'(gnt_o), 32'd0);
        check_eq("rstmid_rvalid2", 32'(rvalid_o), 32'd0);
        check_eq("rstmid_memreq", 32'(mem_req_o), 32'd0);
        check_eq("rstmid_retn", 32'(mem_set_retentive_no), 32'd1);

        // Randomized traffic with varying density, retention toggles, resets.
        dens = 30;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 0) begin
                case ($urandom_range(3))
                    0: dens = 0;
                    1: dens = 5;
                    2: dens = 30;
                    default: dens = 80;
                endcase
            end
            if ($urandom_range(99) == 0) ret_en = ~ret_en;
            rst = ($urandom_range(499) == 0);
            for (int p = 0; p < NP; p++) begin
                if (req[p] && !gnt_seen[p]) begin
                    if ($urandom_range(99) < 3) req[p] = 1'b0;
                end else if (int'($urandom_range(99)) < dens) begin
                    set_port(p, 1'($urandom_range(1)), AW'($urandom_range(NADDR - 1)),
                             $urandom, 4'($urandom_range(15)));
                end else begin
                    req[p] = 1'b0;
                end
            end
            step();
        end
        rst = 1'b0;
        clear_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
